fpga_dbg_indicator: RTL

- Parametrised debug-indicator unit for the FPGA top level. Generalises the fixed debug-signal-to-LED/pin hookup to NUM_CH channels.
- Per channel: synchroniser, edge-based activity detection, selectable LED mode (passthrough / pulse-stretch / toggle / blink-while-active) and a saturating event counter.
- Sits between the SoC debug taps (SPI chip selects, UART TX, GPIOs) and the board LEDs; counters are readable via an external register wrapper.

---
 rtl/fpga_dbg_pkg.sv | 21 ++
 rtl/fpga_dbg_channel.sv | 122 ++++++++++++
 rtl/fpga_dbg_indicator.sv | 63 ++++++
 3 files changed

// File: rtl/fpga_dbg_pkg.sv
// Shared types and width helpers for the debug-indicator channels.
package fpga_dbg_pkg;

    typedef enum logic [1:0] {
        DBG_PASS    = 2'b00,
        DBG_STRETCH = 2'b01,
        DBG_TOGGLE  = 2'b10,
        DBG_BLINK   = 2'b11
    } dbg_mode_e;

    localparam int DBG_STRETCH_CYCLES_DEF = 2500000;
    localparam int DBG_BLINK_HALF_DEF     = 250000;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int dbg_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DBG_TIMER_W_DEF = dbg_cnt_width(DBG_STRETCH_CYCLES_DEF);

endpackage

// File: rtl/fpga_dbg_channel.sv
// One debug channel: synchroniser, rising-edge event, LED mode logic and
// a saturating event counter.
module fpga_dbg_channel
    import fpga_dbg_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter logic ACT_LOW        = 1'b0,
    parameter int   STRETCH_CYCLES = DBG_STRETCH_CYCLES_DEF,
    parameter int   CNT_W          = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             dbg,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    input  logic             blink_phase,
    output logic             led,
    output logic             evt,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int               TIMER_W    = dbg_cnt_width(STRETCH_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   act_reg;
    logic                   act_prev_reg;
    logic                   evt_reg;
    logic                   evt_next;
    logic                   led_reg;
    logic                   led_next;
    logic [TIMER_W-1:0]     timer_reg;
    logic [TIMER_W-1:0]     timer_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    dbg_mode_e              mode_reg;
    dbg_mode_e              mode_cur;

    assign mode_cur = dbg_mode_e'(mode);
    assign evt_next = act_reg & ~act_prev_reg;

    // Synchroniser resets to the inactive level so reset release never
    // looks like an edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg     <= {SYNC_STAGES{ACT_LOW}};
            act_reg      <= 1'b0;
            act_prev_reg <= 1'b0;
            evt_reg      <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], dbg};
            act_reg      <= sync_reg[SYNC_STAGES-1] ^ ACT_LOW;
            act_prev_reg <= act_reg;
            evt_reg      <= evt_next;
        end
    end

    always_comb begin
        led_next   = led_reg;
        timer_next = timer_reg;
        cnt_next   = cnt_reg;

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (evt_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        // A mode change wipes the LED state; any coincident event is only counted.
        if (mode_cur != mode_reg) begin
            led_next   = 1'b0;
            timer_next = '0;
        end else begin
            case (mode_cur)
                DBG_PASS: begin
                    led_next   = act_reg;
                    timer_next = '0;
                end
                DBG_STRETCH, DBG_BLINK: begin
                    if (evt_next) begin
                        timer_next = TIMER_LOAD;
                        led_next   = 1'b1;
                    end else if (timer_reg != '0) begin
                        timer_next = timer_reg - TIMER_W'(1);
                        led_next   = 1'b1;
                    end else begin
                        led_next   = 1'b0;
                    end
                end
                DBG_TOGGLE: begin
                    if (evt_next) begin
                        led_next = ~led_reg;
                    end
                end
                default: begin
                    led_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            led_reg   <= 1'b0;
            timer_reg <= '0;
            cnt_reg   <= '0;
            mode_reg  <= DBG_PASS;
        end else begin
            led_reg   <= led_next;
            timer_reg <= timer_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_cur;
        end
    end

    // In blink mode led_reg marks the active window; the shared phase gates it.
    assign led     = (mode_reg == DBG_BLINK) ? (led_reg & blink_phase) : led_reg;
    assign evt     = evt_reg;
    assign evt_cnt = cnt_reg;

endmodule

// File: rtl/fpga_dbg_indicator.sv
// Debug-indicator top: NUM_CH independent channels plus the blink prescaler
// shared by all of them so blinking LEDs stay phase-aligned.
module fpga_dbg_indicator
    import fpga_dbg_pkg::*;
#(
    parameter int                NUM_CH         = 4,
    parameter int                SYNC_STAGES    = 2,
    parameter logic [NUM_CH-1:0] ACT_LOW_MASK   = 4'b0011,
    parameter int                STRETCH_CYCLES = DBG_STRETCH_CYCLES_DEF,
    parameter int                BLINK_HALF     = DBG_BLINK_HALF_DEF,
    parameter int                CNT_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH-1:0]         dbg_i,
    input  logic [2*NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]         cnt_clr_i,
    output logic [NUM_CH-1:0]         led_o,
    output logic [NUM_CH-1:0]         evt_o,
    output logic [NUM_CH*CNT_W-1:0]   evt_cnt_o
);

    localparam int               PRE_W    = dbg_cnt_width(BLINK_HALF);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF - 1);

    logic [PRE_W-1:0] pre_reg;
    logic             phase_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (pre_reg == PRE_LAST) begin
            pre_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            pre_reg   <= pre_reg + PRE_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            fpga_dbg_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .ACT_LOW        (ACT_LOW_MASK[gi]),
                .STRETCH_CYCLES (STRETCH_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk         (clk_i),
                .srst        (rst_i),
                .dbg         (dbg_i[gi]),
                .mode        (mode_i[2*gi +: 2]),
                .cnt_clr     (cnt_clr_i[gi]),
                .blink_phase (phase_reg),
                .led         (led_o[gi]),
                .evt         (evt_o[gi]),
                .evt_cnt     (evt_cnt_o[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule
